// File: rtl/mmm_pkg.sv
// Shared definitions for the 90-bit Montgomery reduction (REDC) block.
// Holds the default widths, the derived accumulator width and the FSM
// state encoding used by mmm_redc_90b.
package mmm_pkg;
  localparam int DEF_IDW = 90;           // modulus / result width
  localparam int DEF_TW  = 181;          // product input width
  localparam int DEF_WW  = 16;           // reduction digit width
  localparam int DEF_NR  = 6;            // rounds, ceil(IDW/WW)
  localparam int DEF_AW  = DEF_TW + 2;   // accumulator / round-add width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mmm_redc_round.sv
// One word-serial Montgomery reduction round (purely combinational).
//   i_acc : current accumulator (AW bits)
//   i_n   : latched odd modulus N
//   i_n0  : latched -N^-1 mod 2^WW
//   o_acc : (i_acc + m*N) >> WW, with m = (i_acc mod 2^WW) * n0 mod 2^WW
// m is chosen so the low WW bits of the sum are zero, so the shift is exact.
module mmm_redc_round
  import mmm_pkg::*;
#(
  parameter int IDW = DEF_IDW,
  parameter int WW  = DEF_WW,
  parameter int AW  = DEF_AW
) (
  input  logic [AW-1:0]  i_acc,
  input  logic [IDW-1:0] i_n,
  input  logic [WW-1:0]  i_n0,
  output logic [AW-1:0]  o_acc
);
  logic [WW-1:0] w_m;
  logic [AW-1:0] w_mn;
  logic [AW-1:0] w_sum;

  // WW-bit context truncates the product to m mod 2^WW
  assign w_m   = i_acc[WW-1:0] * i_n0;
  assign w_mn  = {{(AW-WW){1'b0}}, w_m} * {{(AW-IDW){1'b0}}, i_n};
  // Full AW-bit add; nothing is dropped before the shift
  assign w_sum = i_acc + w_mn;
  assign o_acc = w_sum >> WW;
endmodule

// File: rtl/mmm_redc_90b.sv
// Montgomery reduction: o_res = i_t * 2^-(NR*WW) mod i_n.
// Word-serial: 1 load cycle, NR round cycles, 1 final-subtract cycle, then
// the result is held until the consumer takes it. One operation at a time.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_t, i_n, i_n0      : product T, odd modulus N, -N^-1 mod 2^WW
//   i_valid / o_ready   : input handshake (o_ready high only in IDLE)
//   o_res               : reduced result, < N for legal inputs
//   o_valid / i_ready   : output handshake
module mmm_redc_90b
  import mmm_pkg::*;
#(
  parameter int IDW = DEF_IDW,
  parameter int TW  = DEF_TW,
  parameter int WW  = DEF_WW,
  parameter int NR  = DEF_NR
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [TW-1:0]  i_t,
  input  logic [IDW-1:0] i_n,
  input  logic [WW-1:0]  i_n0,
  input  logic           i_valid,
  output logic           o_ready,
  output logic [IDW-1:0] o_res,
  output logic           o_valid,
  input  logic           i_ready
);
  localparam int AW = TW + 2;
  localparam int CW = (NR > 1) ? $clog2(NR) : 1;

  state_t         r_state;
  logic [AW-1:0]  r_acc;
  logic [IDW-1:0] r_n;
  logic [WW-1:0]  r_n0;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_res;
  logic           r_valid;
  logic           r_ready;

  logic [AW-1:0]  w_acc_nxt;
  logic           w_ge;
  logic [IDW-1:0] w_sub;

  mmm_redc_round #(
    .IDW (IDW),
    .WW  (WW),
    .AW  (AW)
  ) u_round (
    .i_acc (r_acc),
    .i_n   (r_n),
    .i_n0  (r_n0),
    .o_acc (w_acc_nxt)
  );

  // For legal inputs acc < 2N, so acc-N < N fits in IDW bits and the
  // subtraction can be done on the low IDW bits alone.
  assign w_ge  = (r_acc >= {{(AW-IDW){1'b0}}, r_n});
  assign w_sub = r_acc[IDW-1:0] - r_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_n     <= '0;
      r_n0    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_acc   <= {{(AW-TW){1'b0}}, i_t};
            r_n     <= i_n;
            r_n0    <= i_n0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(NR - 1)) r_state <= SUB;
        end
        SUB: begin
          r_res   <= w_ge ? w_sub : r_acc[IDW-1:0];
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_res   = r_res;
endmodule

// File: tb/tb_mmm_redc_90b.sv
module tb_mmm_redc_90b;
  localparam int IDW = 90;
  localparam int TW  = 181;
  localparam int WW  = 16;

  logic           clk = 1'b0;
  logic           i_rst;
  logic [TW-1:0]  i_t;
  logic [IDW-1:0] i_n;
  logic [WW-1:0]  i_n0;
  logic           i_valid;
  logic           o_ready;
  logic [IDW-1:0] o_res;
  logic           o_valid;
  logic           i_ready;

  always #5 clk = ~clk;

  mmm_redc_90b dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_t     (i_t),
    .i_n     (i_n),
    .i_n0    (i_n0),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_res   (o_res),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  int total = 0;
  int bad   = 0;
  longint cyc = 0;
  int n_acc = 0;
  bit started = 1'b0;

  logic [IDW-1:0] exp_q[$];
  longint         acc_q[$];

  localparam logic [IDW-1:0] N89  = {1'b1, 88'd0, 1'b1};
  localparam logic [IDW-1:0] N3   = 90'd3;
  localparam logic [WW-1:0]  N0_3 = 16'h5555;
  localparam logic [WW-1:0]  N0_89 = 16'hFFFF;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: T * 2^-96 mod N, computing 2^-96 by repeated halving mod N.
  function automatic logic [IDW-1:0] model(input logic [TW-1:0] t, input logic [IDW-1:0] n);
    logic [191:0] nn, x, tm;
    nn = 192'(n);
    x  = 192'd1;
    for (int i = 0; i < 96; i++) x = x[0] ? ((x + nn) >> 1) : (x >> 1);
    tm = 192'(t) % nn;
    return IDW'((tm * x) % nn);
  endfunction

  function automatic logic [IDW-1:0] rand_below(input logic [IDW-1:0] n);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return IDW'(r % 96'(n));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: scoreboard of accepted operands vs. results, latency,
  // hold-while-stalled, and handshake exclusivity, every cycle.
  logic           p_valid = 1'b0;
  logic           p_iready = 1'b0;
  logic           p_rst = 1'b1;
  logic [IDW-1:0] p_res = '0;

  always @(negedge clk) begin
    if (started) begin
      if (i_rst) begin
        exp_q.delete();
        acc_q.delete();
      end else begin
        chk("ready_valid_excl", 192'(o_ready & o_valid), 192'd0);
        if (!p_rst && p_valid && !p_iready) begin
          chk("hold_valid", 192'(o_valid), 192'd1);
          chk("hold_res", 192'(o_res), 192'(p_res));
          chk("hold_ready", 192'(o_ready), 192'd0);
        end
        if (o_valid && !p_valid) begin
          if (acc_q.size() == 0) chk("unexpected_valid", 192'(o_valid), 192'd0);
          else chk("latency", 192'(cyc - acc_q.pop_front()), 192'd8);
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 192'(o_valid), 192'd0);
          else chk("result", 192'(o_res), 192'(exp_q.pop_front()));
        end
        if (i_valid && o_ready) begin
          exp_q.push_back(model(i_t, i_n));
          acc_q.push_back(cyc);
          n_acc <= n_acc + 1;
        end
      end
    end
    p_valid  <= o_valid;
    p_iready <= i_ready;
    p_rst    <= i_rst;
    p_res    <= o_res;
  end

  task automatic run_op(input logic [TW-1:0] t, input logic [IDW-1:0] n,
                        input logic [WW-1:0] n0, input int hold,
                        output logic [IDW-1:0] res);
    int k;
    i_t = t; i_n = n; i_n0 = n0; i_valid = 1'b1;
    k = 0;
    while (!o_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!o_ready) chk("accept_timeout", 192'(o_ready), 192'd1);
    @(posedge clk); #1;
    // scramble inputs: only the latched copies may matter now
    i_valid = 1'b0; i_t = ~t; i_n = ~n; i_n0 = ~n0;
    k = 0;
    while (!o_valid && k < 50) begin @(posedge clk); #1; k++; end
    if (!o_valid) chk("valid_timeout", 192'(o_valid), 192'd1);
    res = o_res;
    if (hold > 0) begin
      i_ready = 1'b0;
      repeat (hold) begin @(posedge clk); #1; end
      i_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_valid_low", 192'(o_valid), 192'd0);
    chk("idle_ready_high", 192'(o_ready), 192'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDW-1:0] r, a, b;
    logic [TW-1:0]  t6[6];
    int k, acc0;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_t = '0; i_n = '0; i_n0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", 192'(o_res), 192'd0);
    chk("rst_valid", 192'(o_valid), 192'd0);
    chk("rst_ready", 192'(o_ready), 192'd1);
    started = 1'b1;
    i_rst = 1'b0;

    // Pin the model with hand-derived values
    chk("model_n3_t1", 192'(model(181'd1, N3)), 192'd1);
    chk("model_n3_t2", 192'(model(181'd2, N3)), 192'd2);
    chk("model_n3_t6", 192'(model(181'd6, N3)), 192'd0);
    chk("model_n89_t1", 192'(model(181'd1, N89)), 192'd1 << 82);
    chk("model_n89_r", 192'(model(181'd1 << 96, N89)), 192'd1);

    // Case 1 / 2: N=3
    run_op(181'd1, N3, N0_3, 0, r); chk("c1_t1", 192'(r), 192'd1);
    run_op(181'd0, N3, N0_3, 0, r); chk("c2_t0", 192'(r), 192'd0);
    run_op(181'd6, N3, N0_3, 0, r); chk("c2_t6", 192'(r), 192'd0);
    run_op(181'd2, N3, N0_3, 0, r); chk("c2_t2", 192'(r), 192'd2);

    // Case 4: consumer stalls 20 cycles in DONE
    run_op(181'd5, N3, N0_3, 20, r); chk("c4_t5", 192'(r), 192'd2);

    // Case 5: reset during round 3
    i_t = 181'd1; i_n = N3; i_n0 = N0_3; i_valid = 1'b1;
    k = 0;
    while (!o_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;           // accept edge
    i_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end  // rounds 1 and 2
    i_rst = 1'b1;
    @(posedge clk); #1;           // would have been round 3
    i_rst = 1'b0;
    chk("c5_ready", 192'(o_ready), 192'd1);
    chk("c5_valid", 192'(o_valid), 192'd0);
    chk("c5_res", 192'(o_res), 192'd0);
    repeat (15) @(posedge clk);
    #1;
    run_op(181'd1, N3, N0_3, 0, r); chk("c5_after", 192'(r), 192'd1);

    // Case 3: random products modulo 2^89+1, first one (N-1)^2
    a = N89 - 90'd1;
    run_op(181'(a) * 181'(a), N89, N0_89, 0, r);
    chk("c3_max", 192'(r), 192'(model(181'(a) * 181'(a), N89)));
    for (int v = 1; v < 1000; v++) begin
      a = rand_below(N89);
      b = rand_below(N89);
      run_op(181'(a) * 181'(b), N89, N0_89, 0, r);
    end

    // Case 6: i_valid held high, back-to-back operands
    for (int j = 0; j < 6; j++) begin
      a = rand_below(N89); b = rand_below(N89);
      t6[j] = 181'(a) * 181'(b);
    end
    acc0 = n_acc;
    i_t = t6[0]; i_n = N89; i_n0 = N0_89; i_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      k = 0;
      while (!o_ready && k < 50) begin @(posedge clk); #1; k++; end
      if (!o_ready) chk("b2b_accept_timeout", 192'(o_ready), 192'd1);
      @(posedge clk); #1;         // accept edge
      if (j < 5) i_t = t6[j+1];
      else i_valid = 1'b0;
      k = 0;
      while (!o_valid && k < 50) begin @(posedge clk); #1; k++; end
      if (!o_valid) chk("b2b_valid_timeout", 192'(o_valid), 192'd1);
      @(posedge clk); #1;         // transfer-out edge
      chk("b2b_ready_after_out", 192'(o_ready), 192'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_accept_count", 192'(n_acc - acc0), 192'd6);
    chk("queue_empty", 192'(exp_q.size()), 192'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
